fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of control_unit and drives its `opcode` input.
- Boots the PC from a vector in instruction memory, fetches one 16-bit word per cycle, and pairs two-word instructions (LDM, SHL, SHR) with their immediate word.
- Emits NOP bubbles on redirect/flush; holds on stall.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: boots the PC from a reset vector, fetches one 16-bit word per
// cycle and pairs two-word instructions with their immediate word before they
// are handed to decode through the IF/ID register. State changes on the falling
// clock edge, so that opcode is already stable at the rising edge of the decode stage.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter logic [15:0]           NOP_WORD   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [15:0]           imem_data,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [15:0]           ifid_instr,
    output logic [4:0]            opcode,
    output logic [15:0]           ifid_imm,
    output logic [ADDR_WIDTH-1:0] ifid_pc,
    output logic                  ifid_valid,
    output logic                  booting
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_IMM   = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [15:0]           r_instr, w_instr_nxt;
    logic [15:0]           r_imm, w_imm_nxt;
    logic [ADDR_WIDTH-1:0] r_ifpc, w_ifpc_nxt;
    logic                  r_valid, w_valid_nxt;
    logic [15:0]           r_pend_instr, w_pend_instr_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_pc, w_pend_pc_nxt;
    // One extra bubble after a two-word instruction, so the decode stage's
    // post-immediate flush lands on a bubble instead of a real instruction.
    logic                  r_post_bub, w_post_bub_nxt;

    logic [ADDR_WIDTH-1:0] w_boot_vec;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [4:0]            w_op;
    logic                  w_two_word;

    // The reset vector is zero-extended when the PC is wider than a memory word.
    if (ADDR_WIDTH > 16) begin : g_vec_ext
        assign w_boot_vec = {{(ADDR_WIDTH-16){1'b0}}, imem_data};
    end else begin : g_vec_trunc
        assign w_boot_vec = imem_data[ADDR_WIDTH-1:0];
    end

    // The PC wraps modulo 2^ADDR_WIDTH with no indication.
    assign w_pc_inc   = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign w_op       = imem_data[15:11];
    assign w_two_word = (w_op == 5'd14) || (w_op == 5'd30) || (w_op == 5'd31);

    assign imem_addr  = (r_state == S_BOOT) ? BOOT_ADDR : r_pc;
    assign booting    = (r_state == S_BOOT);
    assign ifid_instr = r_instr;
    assign opcode     = r_instr[15:11];
    assign ifid_imm   = r_imm;
    assign ifid_pc    = r_ifpc;
    assign ifid_valid = r_valid;

    // State register: all fetch state advances on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_pc         <= BOOT_ADDR;
            r_instr      <= NOP_WORD;
            r_imm        <= '0;
            r_ifpc       <= '0;
            r_valid      <= 1'b0;
            r_pend_instr <= NOP_WORD;
            r_pend_pc    <= '0;
            r_post_bub   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_imm        <= w_imm_nxt;
            r_ifpc       <= w_ifpc_nxt;
            r_valid      <= w_valid_nxt;
            r_pend_instr <= w_pend_instr_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_post_bub   <= w_post_bub_nxt;
        end
    end

    // Next-state logic: redirect beats stall beats normal fetch; BOOT ignores both.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instr_nxt      = r_instr;
        w_imm_nxt        = r_imm;
        w_ifpc_nxt       = r_ifpc;
        w_valid_nxt      = r_valid;
        w_pend_instr_nxt = r_pend_instr;
        w_pend_pc_nxt    = r_pend_pc;
        w_post_bub_nxt   = r_post_bub;
        case (r_state)
            S_BOOT: begin
                w_pc_nxt    = w_boot_vec;
                w_state_nxt = S_FETCH;
            end
            default: begin
                if (redirect) begin
                    // Flush: a half-fetched two-word instruction is dropped.
                    w_pc_nxt         = redirect_target;
                    w_instr_nxt      = NOP_WORD;
                    w_imm_nxt        = '0;
                    w_ifpc_nxt       = '0;
                    w_valid_nxt      = 1'b0;
                    w_pend_instr_nxt = NOP_WORD;
                    w_pend_pc_nxt    = '0;
                    w_post_bub_nxt   = 1'b0;
                    w_state_nxt      = S_FETCH;
                end else if (!stall) begin
                    if (r_state == S_IMM) begin
                        w_instr_nxt    = r_pend_instr;
                        w_imm_nxt      = imem_data;
                        w_ifpc_nxt     = r_pend_pc;
                        w_valid_nxt    = 1'b1;
                        w_pc_nxt       = w_pc_inc;
                        w_post_bub_nxt = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end else if (r_post_bub) begin
                        // PC holds for the extra bubble cycle.
                        w_instr_nxt    = NOP_WORD;
                        w_imm_nxt      = '0;
                        w_ifpc_nxt     = '0;
                        w_valid_nxt    = 1'b0;
                        w_post_bub_nxt = 1'b0;
                    end else if (w_two_word) begin
                        w_instr_nxt      = NOP_WORD;
                        w_imm_nxt        = '0;
                        w_ifpc_nxt       = '0;
                        w_valid_nxt      = 1'b0;
                        w_pend_instr_nxt = imem_data;
                        w_pend_pc_nxt    = r_pc;
                        w_pc_nxt         = w_pc_inc;
                        w_state_nxt      = S_IMM;
                    end else begin
                        w_instr_nxt = imem_data;
                        w_imm_nxt   = '0;
                        w_ifpc_nxt  = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 256-word instruction memory (aliased over the
// 20-bit address space), a per-cycle queue of expected IF/ID contents, and
// directed scenarios for boot, two-word pairing, redirect, stall and wrap.
module tb_fetch_stage;

    logic        clk = 1'b1;
    logic        rst_n = 1'b0;
    logic [19:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [19:0] redirect_target = '0;
    logic [15:0] ifid_instr;
    logic [4:0]  opcode;
    logic [15:0] ifid_imm;
    logic [19:0] ifid_pc;
    logic        ifid_valid;
    logic        booting;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic [15:0] imm;
        logic [19:0] pc;
        logic [19:0] addr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_data = mem[8'(imem_addr)];

    fetch_stage #(.ADDR_WIDTH(20), .BOOT_ADDR(20'h0), .NOP_WORD(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .ifid_instr(ifid_instr), .opcode(opcode), .ifid_imm(ifid_imm),
        .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .booting(booting)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic v, input logic [4:0] op, input logic [15:0] imm,
                        input logic [19:0] pc, input logic [19:0] addr);
        exp_t e;
        e.v = v; e.op = op; e.imm = imm; e.pc = pc; e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic bub(input logic [19:0] addr);
        push(1'b0, 5'd0, 16'h0, 20'h0, addr);
    endtask

    // One cycle: sample at the rising edge (state moves on the falling edge).
    task automatic sb_step(input string tag);
        exp_t e;
        @(posedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(ifid_valid), 32'(e.v));
            chk({tag, "_addr"}, 32'(imem_addr), 32'(e.addr));
            chk({tag, "_booting"}, 32'(booting), 32'd0);
            if (e.v) begin
                chk({tag, "_opcode"}, 32'(opcode), 32'(e.op));
                chk({tag, "_imm"}, 32'(ifid_imm), 32'(e.imm));
                chk({tag, "_pc"}, 32'(ifid_pc), 32'(e.pc));
            end else begin
                chk({tag, "_bub_instr"}, 32'(ifid_instr), 32'h0);
                chk({tag, "_bub_imm"}, 32'(ifid_imm), 32'h0);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_booting"}, 32'(booting), 32'd1);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
        chk({tag, "_instr"}, 32'(ifid_instr), 32'h0);
        chk({tag, "_imm"}, 32'(ifid_imm), 32'h0);
        chk({tag, "_pc"}, 32'(ifid_pc), 32'h0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
    endtask

    // Reset with a fresh memory image whose word 0 is the boot vector.
    task automatic reset_dut(input string tag, input logic [15:0] vec);
        @(posedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = vec;
        sb.delete();
        #1;
        chk_reset_vals({tag, "_rst"});
        @(posedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_boot_hi"}, 32'(booting), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Boot: vector 0x10 -> SETC issues two cycles after release.
        reset_dut("boot", 16'h0010);
        mem[8'h10] = 16'h0800;
        bub(20'h10);
        push(1'b1, 5'd1, 16'h0, 20'h10, 20'h11);
        for (int i = 0; i < 2; i++) sb_step("boot");

        // Straight-line single-word instructions.
        reset_dut("line", 16'h0010);
        mem[8'h10] = 16'hC000; mem[8'h11] = 16'hC800; mem[8'h12] = 16'hD000;
        bub(20'h10);
        push(1'b1, 5'd24, 16'h0, 20'h10, 20'h11);
        push(1'b1, 5'd25, 16'h0, 20'h11, 20'h12);
        push(1'b1, 5'd26, 16'h0, 20'h12, 20'h13);
        for (int i = 0; i < 4; i++) sb_step("line");

        // Two-word: bubble, paired issue, post-immediate bubble, next instr.
        reset_dut("two", 16'h0010);
        mem[8'h10] = 16'h7000; mem[8'h11] = 16'hBEEF; mem[8'h12] = 16'hC800;
        bub(20'h10);
        bub(20'h11);
        push(1'b1, 5'd14, 16'hBEEF, 20'h10, 20'h12);
        bub(20'h12);
        push(1'b1, 5'd25, 16'h0, 20'h12, 20'h13);
        for (int i = 0; i < 5; i++) sb_step("two");

        // Redirect during IMM aborts the two-word instruction.
        reset_dut("rdimm", 16'h0020);
        mem[8'h20] = 16'hF000; mem[8'h21] = 16'h1234; mem[8'h40] = 16'h4800;
        bub(20'h20); bub(20'h21); bub(20'h40);
        push(1'b1, 5'd9, 16'h0, 20'h40, 20'h41);
        sb_step("rdimm");
        sb_step("rdimm");
        redirect = 1'b1; redirect_target = 20'h40;
        sb_step("rdimm");
        redirect = 1'b0;
        sb_step("rdimm");

        // Stall freezes IF/ID and the fetch address; redirect beats stall.
        reset_dut("stall", 16'h0010);
        mem[8'h10] = 16'hC000; mem[8'h11] = 16'hC800; mem[8'h55] = 16'h6000;
        bub(20'h10);
        for (int i = 0; i < 4; i++) push(1'b1, 5'd24, 16'h0, 20'h10, 20'h11);
        bub(20'h55);
        push(1'b1, 5'd12, 16'h0, 20'h55, 20'h56);
        sb_step("stall");
        sb_step("stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) sb_step("stall");
        redirect = 1'b1; redirect_target = 20'h55;
        sb_step("stall");
        redirect = 1'b0; stall = 1'b0;
        sb_step("stall");
        // Asynchronous reset between edges, mid-stall, with a valid instruction held.
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async");

        // Single-word instruction at the last address: PC wraps to 0.
        reset_dut("wrap1", 16'h0010);
        mem[8'h10] = 16'hC000; mem[8'hFF] = 16'h4800;
        bub(20'h10); bub(20'hFFFFF);
        push(1'b1, 5'd9, 16'h0, 20'hFFFFF, 20'h0);
        sb_step("wrap1");
        redirect = 1'b1; redirect_target = 20'hFFFFF;
        sb_step("wrap1");
        redirect = 1'b0;
        sb_step("wrap1");

        // Two-word instruction at the last address: immediate read from 0.
        reset_dut("wrap2", 16'h0010);
        mem[8'h10] = 16'hC000; mem[8'hFF] = 16'h7000;
        bub(20'h10); bub(20'hFFFFF); bub(20'h0);
        push(1'b1, 5'd14, 16'h0010, 20'hFFFFF, 20'h1);
        sb_step("wrap2");
        redirect = 1'b1; redirect_target = 20'hFFFFF;
        sb_step("wrap2");
        redirect = 1'b0;
        sb_step("wrap2");
        sb_step("wrap2");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
